// File: rtl/tdr_scan_driver.sv
// tdr_scan_driver: runs one complete DR scan on a test data register (TDR).
// Each scan drives Capture, then LEN shift cycles, then an Update unless the scan is read-only.
// During the shift, the latched write word goes out LSB first on SI.
// The captured word is assembled from SO into rdata.
//
// Optional build macro: TDR_SCAN_HOLD_EN
//   Adds the 'hold' input, the Pause-DR analogue.
//   While hold is sampled high in SHIFT, the next cycle is a paused cycle:
//   ShiftDR=0, SI=0, counter frozen, rdata unchanged, Enable stays 1.
//
// Ports:
//   TCLK        scan clock (single clock)
//   TRESETN     asynchronous active-low reset
//   start       scan request, accepted only in IDLE
//   skip_update latched with start; 1 = no Update cycle
//   wdata       word shifted into the TDR, latched on accept
//   busy        high in every state but IDLE
//   done        one-cycle pulse at scan end; rdata valid from here
//   rdata       word captured from the TDR
//   CaptureDR, ShiftDR, UpdateDR, Enable, SI   registered TDR controls
//   SO          TDR serial output (serial register bit 0)
//   hold        (TDR_SCAN_HOLD_EN only) pause shifting
module tdr_scan_driver #(
  parameter int unsigned LEN = 33,
  parameter int unsigned CW  = 6
) (
`ifdef TDR_SCAN_HOLD_EN
  input  logic           hold,
`endif
  input  logic           TCLK,
  input  logic           TRESETN,
  input  logic           start,
  input  logic           skip_update,
  input  logic [LEN-1:0] wdata,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] rdata,
  output logic           CaptureDR,
  output logic           ShiftDR,
  output logic           UpdateDR,
  output logic           Enable,
  output logic           SI,
  input  logic           SO
);

  typedef enum logic [2:0] {StIdle, StCapture, StShift, StUpdate, StDone} state_e;

  localparam logic [CW-1:0] LastIdx = CW'(LEN - 1);

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  logic [LEN-1:0] r_wdata;
  logic [LEN-1:0] r_rdata;
  logic           r_skip;
  logic           r_busy, r_done, r_capture, r_shift, r_update, r_enable, r_si;

  logic           w_hold;
  logic [LEN-1:0] w_wdata_shr;
  logic [LEN-1:0] w_rdata_shr;

`ifdef TDR_SCAN_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  // Bit 0 of the write copy is always the next bit to send.
  assign w_wdata_shr = r_wdata >> 1;

  generate
    if (LEN > 1) begin : g_rd_wide
      assign w_rdata_shr = {SO, r_rdata[LEN-1:1]};
    end else begin : g_rd_single
      assign w_rdata_shr = SO;
    end
  endgenerate

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_skip    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_capture <= 1'b0;
      r_shift   <= 1'b0;
      r_update  <= 1'b0;
      r_enable  <= 1'b0;
      r_si      <= 1'b0;
    end else begin
      // Output defaults; each branch raises the controls for the state being entered.
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_capture <= 1'b0;
      r_shift   <= 1'b0;
      r_update  <= 1'b0;
      r_enable  <= 1'b0;
      r_si      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state   <= StCapture;
            r_wdata   <= wdata;
            r_skip    <= skip_update;
            r_capture <= 1'b1;
            r_enable  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        StCapture: begin
          r_state  <= StShift;
          r_cnt    <= '0;
          r_enable <= 1'b1;
          r_shift  <= !w_hold;
          r_si     <= !w_hold && r_wdata[0];
        end
        StShift: begin
          // r_shift marks a real shift cycle; a low r_shift here is a paused cycle.
          if (r_shift) begin
            r_rdata <= w_rdata_shr;
            if (r_cnt == LastIdx) begin
              if (r_skip) begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end else begin
                r_state  <= StUpdate;
                r_update <= 1'b1;
                r_enable <= 1'b1;
              end
            end else begin
              r_cnt    <= r_cnt + CW'(1);
              r_wdata  <= w_wdata_shr;
              r_enable <= 1'b1;
              r_shift  <= !w_hold;
              r_si     <= !w_hold && w_wdata_shr[0];
            end
          end else begin
            r_enable <= 1'b1;
            r_shift  <= !w_hold;
            r_si     <= !w_hold && r_wdata[0];
          end
        end
        StUpdate: begin
          r_state <= StDone;
          r_done  <= 1'b1;
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign CaptureDR = r_capture;
  assign ShiftDR   = r_shift;
  assign UpdateDR  = r_update;
  assign Enable    = r_enable;
  assign SI        = r_si;

endmodule
